logic_shift_unit: RTL and testbench

- Parametrised next-generation ALU logic unit.
- Adds XOR/XNOR and multi-cycle iterative shifts to the bitwise ops, a valid/ready handshake on input and output, and a zero flag.
- Sits beside the arithmetic unit in the ALU, fed by the ALU controller. Results are held until the consumer accepts them.

---
 rtl/alu_pkg.sv | 19 +
 rtl/lu_bitwise_core.sv | 26 ++
 rtl/logic_shift_unit.sv | 128 ++++++++++++
 tb/tb_logic_shift_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit opcodes and the logic/shift unit FSM encoding.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/lu_bitwise_core.sv
// Combinational bitwise operations on already zero-extended operands.
module lu_bitwise_core
  import alu_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic [OUT_WIDTH-1:0] a,
  input  logic [OUT_WIDTH-1:0] b,
  input  logic [2:0]           op,
  output logic [OUT_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;  // shifts are handled by the iterative datapath
    endcase
  end

endmodule

// File: rtl/logic_shift_unit.sv
// ALU logic unit: single-cycle bitwise ops and iterative 1-bit-per-cycle shifts,
// with valid/ready handshakes and a result that holds until accepted.
module logic_shift_unit
  import alu_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 zero,
  output logic                 busy
);

  localparam int unsigned SH_W = $clog2(OUT_WIDTH);

  state_e               state_q, state_d;
  logic [OUT_WIDTH-1:0] result_q, result_d;
  logic                 zero_q, zero_d;
  logic [OUT_WIDTH-1:0] work_q, work_d;
  logic [SH_W-1:0]      cnt_q, cnt_d;
  logic                 dir_q, dir_d;  // 1: shift right

  logic [OUT_WIDTH-1:0] a_ext, b_ext, logic_y, work_shifted;
  logic [SH_W-1:0]      shamt;
  logic                 is_shift;

  assign a_ext    = OUT_WIDTH'(A);
  assign b_ext    = OUT_WIDTH'(B);
  assign shamt    = b_ext[SH_W-1:0];
  assign is_shift = (op == OP_SHL) || (op == OP_SHR);

  lu_bitwise_core #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_core (
    .a (a_ext),
    .b (b_ext),
    .op(op),
    .y (logic_y)
  );

  assign work_shifted = dir_q ? (work_q >> 1) : (work_q << 1);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    if (clr) begin
      // Flush wins over a same-cycle accept; result and zero are retained.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (is_shift) begin
              work_d = a_ext;
              cnt_d  = shamt;
              dir_d  = (op == OP_SHR);
              if (shamt == '0) begin
                result_d = a_ext;
                zero_d   = (a_ext == '0);
                state_d  = StDone;
              end else begin
                state_d = StShift;
              end
            end else begin
              result_d = logic_y;
              zero_d   = (logic_y == '0);
              state_d  = StDone;
            end
          end
        end
        StShift: begin
          work_d = work_shifted;
          cnt_d  = cnt_q - SH_W'(1);
          if (cnt_q == SH_W'(1)) begin
            result_d = work_shifted;
            zero_d   = (work_shifted == '0);
            state_d  = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      work_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StShift);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_logic_shift_unit.sv
// Scoreboard bench for logic_shift_unit: driver pushes model predictions, a
// negedge monitor pops and compares on every output handshake.
module tb_logic_shift_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        busy;

  logic_shift_unit #(
    .IN_WIDTH (8),
    .OUT_WIDTH(16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] res;
    logic        z;
    int          lat;
    int          vcyc;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          rand_rdy = 0;
  bit          seen = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: zero-extend, apply the opcode arithmetically, keep 16 bits.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    exp_t        e;
    int unsigned ax = a;
    int unsigned bx = b;
    int unsigned n  = bx % 16;
    int unsigned r;
    case (o)
      3'd0:    r = ax & bx;
      3'd1:    r = ax | bx;
      3'd2:    r = ~(ax & bx);
      3'd3:    r = ~(ax | bx);
      3'd4:    r = ax ^ bx;
      3'd5:    r = ~(ax ^ bx);
      3'd6:    r = ax << n;
      default: r = ax >> n;
    endcase
    r     = r & 32'hFFFF;
    e.res = r[15:0];
    e.z   = (r == 0);
    e.lat = (o >= 3'd6 && n > 0) ? int'(n) + 1 : 1;
    e.vcyc = 0;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                       input bit push, output int acc);
    exp_t e;
    int   n = 0;
    A = a; B = b; op = o; in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("accept_wait", {31'd0, in_ready}, 32'd1);
    acc = cyc;
    if (push) begin
      e      = model(a, b, o);
      e.vcyc = cyc + e.lat;
      q.push_back(e);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!out_valid) begin
        seen = 0;
      end else begin
        if (!seen) begin
          seen = 1;
          if (q.size() == 0) check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
          else check("latency", cyc, q[0].vcyc);
        end
        if (out_ready && q.size() != 0) begin
          e = q.pop_front();
          check("result", {16'd0, result}, {16'd0, e.res});
          check("zero", {31'd0, zero}, {31'd0, e.z});
          seen = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int a0, a1, nb;
    logic [15:0] held;
    RST = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; op = '0;
    idle_cycles(2);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    RST = 1'b1;
    idle_cycles(1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Logic ops back to back: accepts two cycles apart.
    issue(8'hF0, 8'h3C, 3'd0, 1, a0);
    issue(8'hF0, 8'h3C, 3'd3, 1, a1);
    check("b2b_spacing", a1 - a0, 32'd2);
    issue(8'hAA, 8'hAA, 3'd5, 1, a0);
    issue(8'h5A, 8'h5A, 3'd4, 1, a1);
    check("b2b_spacing2", a1 - a0, 32'd2);
    drain();

    // SHL by 4: busy for exactly 4 cycles, then 16'h0810.
    issue(8'h81, 8'd4, 3'd6, 1, a0);
    nb = 0;
    while (busy && nb < 50) begin
      nb++;
      idle_cycles(1);
    end
    check("shl4_busy_cycles", nb, 32'd4);
    check("shl4_result", {16'd0, result}, 32'h0810);
    drain();
    issue(8'h81, 8'd0, 3'd7, 1, a0);
    issue(8'h01, 8'd15, 3'd6, 1, a0);
    drain();

    // Backpressure: result holds, no new accept while held.
    out_ready = 1'b0;
    issue(8'hF0, 8'h3C, 3'd0, 1, a0);
    held = result;
    repeat (5) begin
      idle_cycles(1);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", {16'd0, result}, 32'h0030);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    idle_cycles(1);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // clr mid-shift: back to idle, no output, result retained.
    issue(8'h33, 8'd8, 3'd6, 0, a0);
    idle_cycles(1);
    check("clr_busy_before", {31'd0, busy}, 32'd1);
    clr = 1'b1;
    idle_cycles(1);
    clr = 1'b0;
    check("clr_busy_after", {31'd0, busy}, 32'd0);
    check("clr_in_ready", {31'd0, in_ready}, 32'd1);
    check("clr_result_kept", {16'd0, result}, {16'd0, held});
    idle_cycles(12);

    // clr with in_valid in idle: not accepted.
    A = 8'hFF; B = 8'hFF; op = 3'd1; in_valid = 1'b1; clr = 1'b1;
    idle_cycles(1);
    in_valid = 1'b0; clr = 1'b0;
    check("clr_accept_in_ready", {31'd0, in_ready}, 32'd1);
    check("clr_accept_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_accept_result", {16'd0, result}, {16'd0, held});
    idle_cycles(3);

    // Randomized ops with random consumer backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      issue(8'($urandom), 8'($urandom_range(0, 20)), 3'($urandom_range(0, 7)), 1, a0);
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    drain();

    // Reset mid-shift: operation lost, reset values restored.
    issue(8'h01, 8'd15, 3'd6, 0, a0);
    idle_cycles(3);
    RST = 1'b0;
    #1;
    check("midrst_result", {16'd0, result}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    idle_cycles(1);
    RST = 1'b1;
    idle_cycles(1);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    idle_cycles(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
